// File: rtl/ysyx_22040237_lsu.sv
// Load/store stage: one memory transaction per instruction over a valid/ready
// bus, returning an aligned and extended writeback result.
module ysyx_22040237_lsu #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              rd_wr_en_i,
  input  logic [4:0]        rd_idx_i,
  input  logic [XLEN-1:0]   alu_res_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic              mem_rd_i,
  input  logic              mem_wr_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_we_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [XLEN-1:0]   req_wdata_o,
  output logic [7:0]        req_wstrb_o,
  input  logic              rsp_valid_i,
  input  logic [XLEN-1:0]   rsp_rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              wb_en_o,
  output logic [4:0]        wb_idx_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t              state_reg;
  logic                req_we_reg;
  logic [ADDR_W-1:0]   req_addr_reg;
  logic [XLEN-1:0]     req_wdata_reg;
  logic [7:0]          req_wstrb_reg;
  logic                wb_en_reg;
  logic [4:0]          wb_idx_reg;
  logic [XLEN-1:0]     wb_data_reg;
  logic                misalign_reg;
  logic [2:0]          off_reg;
  logic [1:0]          size_reg;
  logic                uns_reg;
  logic                load_reg;

  logic [2:0]          in_off;
  logic                in_mem;
  logic                in_mis;
  logic [7:0]          in_strb;
  logic [XLEN-1:0]     lane;
  logic [XLEN-1:0]     load_val;

  assign in_off = alu_res_i[2:0];
  assign in_mem = mem_rd_i | mem_wr_i;

  always_comb begin
    in_mis  = 1'b0;
    in_strb = 8'h01;
    case (mem_size_i)
      2'd0: begin in_mis = 1'b0;               in_strb = 8'h01; end
      2'd1: begin in_mis = in_off[0];          in_strb = 8'h03; end
      2'd2: begin in_mis = in_off[1:0] != 2'd0; in_strb = 8'h0F; end
      default: begin in_mis = in_off != 3'd0;  in_strb = 8'hFF; end
    endcase
    in_mis = in_mis & in_mem;
  end

  // Read data is 8-byte aligned; move the addressed byte lane down to bit 0.
  assign lane = rsp_rdata_i >> {off_reg, 3'b000};

  always_comb begin
    load_val = lane;
    case (size_reg)
      2'd0: load_val = {{(XLEN-8){~uns_reg & lane[7]}}, lane[7:0]};
      2'd1: load_val = {{(XLEN-16){~uns_reg & lane[15]}}, lane[15:0]};
      2'd2: load_val = {{(XLEN-32){~uns_reg & lane[31]}}, lane[31:0]};
      default: load_val = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      req_we_reg    <= 1'b0;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
      req_wstrb_reg <= '0;
      wb_en_reg     <= 1'b0;
      wb_idx_reg    <= '0;
      wb_data_reg   <= '0;
      misalign_reg  <= 1'b0;
      off_reg       <= '0;
      size_reg      <= '0;
      uns_reg       <= 1'b0;
      load_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid_i) begin
            wb_idx_reg    <= rd_idx_i;
            wb_en_reg     <= rd_wr_en_i & (rd_idx_i != 5'd0) & ~mem_wr_i & ~in_mis;
            wb_data_reg   <= in_mem ? '0 : alu_res_i;
            misalign_reg  <= in_mis;
            off_reg       <= in_off;
            size_reg      <= mem_size_i;
            uns_reg       <= mem_unsigned_i;
            load_reg      <= mem_rd_i;
            req_we_reg    <= mem_wr_i;
            req_addr_reg  <= {alu_res_i[ADDR_W-1:3], 3'b000};
            req_wdata_reg <= mem_wr_i ? (store_data_i << {in_off, 3'b000}) : '0;
            req_wstrb_reg <= mem_wr_i ? (in_strb << in_off) : 8'h00;
            state_reg     <= (in_mem & ~in_mis) ? REQ : DONE;
          end
        end
        REQ: begin
          if (req_ready_i) state_reg <= RESP;
        end
        RESP: begin
          if (rsp_valid_i) begin
            if (load_reg) wb_data_reg <= load_val;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Everything is forced quiet while reset is held, even before the first edge.
  assign in_ready_o  = rst & (state_reg == IDLE);
  assign req_valid_o = rst & (state_reg == REQ);
  assign out_valid_o = rst & (state_reg == DONE);
  assign req_we_o    = rst & req_we_reg;
  assign req_addr_o  = rst ? req_addr_reg  : '0;
  assign req_wdata_o = rst ? req_wdata_reg : '0;
  assign req_wstrb_o = rst ? req_wstrb_reg : 8'h00;
  assign wb_en_o     = rst & wb_en_reg;
  assign wb_idx_o    = rst ? wb_idx_reg    : 5'd0;
  assign wb_data_o   = rst ? wb_data_reg   : '0;
  assign misalign_o  = rst & misalign_reg;

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// Scoreboard bench: byte-level memory model predicts bus requests and writeback
// results; a bus responder and an output monitor check them independently.
module tb_ysyx_22040237_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, rd_wr_en, mem_rd, mem_wr, mem_unsigned;
  logic [4:0]  rd_idx;
  logic [63:0] alu_res, store_data;
  logic [1:0]  mem_size;
  logic        req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        out_valid, out_ready, wb_en, misalign;
  logic [4:0]  wb_idx;
  logic [63:0] wb_data;

  always #5 clk = ~clk;

  ysyx_22040237_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .rd_wr_en_i(rd_wr_en), .rd_idx_i(rd_idx), .alu_res_i(alu_res),
    .store_data_i(store_data), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
    .mem_size_i(mem_size), .mem_unsigned_i(mem_unsigned),
    .req_valid_o(req_valid), .req_ready_i(req_ready), .req_we_o(req_we),
    .req_addr_o(req_addr), .req_wdata_o(req_wdata), .req_wstrb_o(req_wstrb),
    .rsp_valid_i(rsp_valid), .rsp_rdata_i(rsp_rdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .wb_en_o(wb_en), .wb_idx_o(wb_idx), .wb_data_o(wb_data), .misalign_o(misalign)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_t;

  typedef struct {
    logic        en;
    logic [4:0]  idx;
    logic [63:0] data;
    logic        chk_data;
    logic        mis;
  } out_t;

  localparam logic [63:0] BASE = 64'h8000_0000;

  req_t       req_q[$];
  out_t       out_q[$];
  logic [7:0] mem_ref[64];
  logic [7:0] mem_bus[64];
  int         checks = 0;
  int         errors = 0;
  logic       bus_auto = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as bytes, sizes as byte counts.
  task automatic issue(input logic wr_en, input logic [4:0] idx, input logic [63:0] alu,
                       input logic [63:0] sd, input logic ld, input logic st,
                       input logic [1:0] sz, input logic uns);
    out_t o;
    req_t r;
    int n, off, base;
    logic mis, acc;
    logic [63:0] v;
    n    = 1 << sz;
    off  = int'(alu % 64'd8);
    mis  = (ld || st) && (off % n != 0);
    base = int'(alu - BASE);
    o.idx = idx;
    o.mis = mis;
    o.en  = wr_en && (idx != 0) && !st && !mis;
    o.chk_data = !mis && !st;
    o.data = alu;
    if (ld && !mis) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (64'(mem_ref[base + i]) << (8 * i));
      if (!uns && n < 8 && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      o.data = v;
    end
    if ((ld || st) && !mis) begin
      r.we    = st;
      r.addr  = alu & ~64'h7;
      r.wdata = st ? (sd << (8 * off)) : 64'd0;
      r.wstrb = 8'h00;
      if (st) begin
        for (int i = 0; i < n; i++) begin
          r.wstrb[off + i]   = 1'b1;
          mem_ref[base + i] = sd[8 * i +: 8];
        end
      end
      req_q.push_back(r);
    end
    out_q.push_back(o);

    @(posedge clk); #1;
    in_valid = 1'b1; rd_wr_en = wr_en; rd_idx = idx; alu_res = alu; store_data = sd;
    mem_rd = ld; mem_wr = st; mem_size = sz; mem_unsigned = uns;
    acc = 1'b0;
    for (int c = 0; c < 300 && !acc; c++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("accept_in_time", 64'(acc), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if ((ld || st) && !mis) chk("req_valid_latency", 64'(req_valid), 64'd1);
    else                    chk("out_valid_latency", 64'(out_valid), 64'd1);
  endtask

  // Writeback monitor: held values are compared every stalled cycle.
  always @(negedge clk) begin
    if (rst && (req_valid || out_valid)) chk("in_ready_busy", 64'(in_ready), 64'd0);
    if (rst && out_valid) begin
      chk("out_expected", 64'(out_q.size() != 0), 64'd1);
      if (out_q.size() != 0) begin
        chk("wb_en", 64'(wb_en), 64'(out_q[0].en));
        chk("wb_idx", 64'(wb_idx), 64'(out_q[0].idx));
        chk("misalign", 64'(misalign), 64'(out_q[0].mis));
        if (out_q[0].chk_data) chk("wb_data", wb_data, out_q[0].data);
        if (out_ready) void'(out_q.pop_front());
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Bus responder with random request and response stalls.
  initial begin
    int k, lb;
    req_t e;
    logic [63:0] line;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 64'd0;
    forever begin
      @(posedge clk); #1;
      if (!bus_auto) continue;
      rsp_valid = 1'b0;
      if (rst && req_valid) begin
        chk("req_expected", 64'(req_q.size() != 0), 64'd1);
        if (req_q.size() == 0) continue;
        e = req_q[0];
        k = $urandom_range(0, 4);
        for (int s = 0; s <= k; s++) begin
          if (s == k) req_ready = 1'b1;
          @(negedge clk);
          chk("req_we", 64'(req_we), 64'(e.we));
          chk("req_addr", req_addr, e.addr);
          chk("req_wdata", req_wdata, e.wdata);
          chk("req_wstrb", 64'(req_wstrb), 64'(e.wstrb));
          if (s < k) begin @(posedge clk); #1; end
        end
        void'(req_q.pop_front());
        lb = int'(req_addr - BASE);
        line = {$urandom, $urandom};
        if (lb >= 0 && lb <= 56) begin
          for (int b = 0; b < 8; b++) begin
            if (req_wstrb[b]) mem_bus[lb + b] = req_wdata[8 * b +: 8];
            if (!req_we) line[8 * b +: 8] = mem_bus[lb + b];
          end
        end
        @(posedge clk); #1;
        req_ready = 1'b0;
        k = $urandom_range(0, 3);
        repeat (k) begin @(posedge clk); #1; end
        rsp_valid = 1'b1;
        rsp_rdata = line;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    logic [1:0] sz;
    logic acc;
    rst = 1'b0; in_valid = 1'b0; rd_wr_en = 1'b0; rd_idx = 5'd0; alu_res = 64'd0;
    store_data = 64'd0; mem_rd = 1'b0; mem_wr = 1'b0; mem_size = 2'd0; mem_unsigned = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem_ref[i] = 8'($urandom);
      mem_bus[i] = mem_ref[i];
    end
    for (int i = 0; i < 8; i++) begin
      mem_ref[i] = (i == 3) ? 8'hF0 : 8'h00;
      mem_bus[i] = mem_ref[i];
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_wb_en", 64'(wb_en), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_req_addr", req_addr, 64'd0);
    chk("rst_req_wstrb", 64'(req_wstrb), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus_auto = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    issue(1'b1, 5'd5, 64'h1234, 64'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    issue(1'b1, 5'd7, 64'h8000_0003, 64'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    issue(1'b1, 5'd8, 64'h8000_0003, 64'd0, 1'b1, 1'b0, 2'd0, 1'b1);
    issue(1'b1, 5'd9, 64'h8000_0006, 64'hABCD, 1'b0, 1'b1, 2'd1, 1'b0);
    issue(1'b1, 5'd10, 64'h8000_0002, 64'd0, 1'b1, 1'b0, 2'd2, 1'b0);
    issue(1'b1, 5'd11, 64'h8000_0004, 64'd0, 1'b1, 1'b0, 2'd2, 1'b1);

    for (int t = 0; t < 160; t++) begin
      op = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      if (op == 0)
        issue(1'($urandom), 5'($urandom), {$urandom, $urandom}, 64'd0, 1'b0, 1'b0, sz, 1'b0);
      else
        issue(1'($urandom), 5'($urandom), BASE + 64'($urandom_range(0, 63)),
              {$urandom, $urandom}, op == 1, op == 2, sz, 1'($urandom));
    end

    acc = 1'b0;
    for (int c = 0; c < 500 && !acc; c++) begin
      @(negedge clk);
      if (out_q.size() == 0 && req_q.size() == 0 && in_ready) acc = 1'b1;
    end
    chk("drain_done", 64'(acc), 64'd1);

    // Abandon a load in RESP via reset, then deliver a stale response.
    @(posedge clk); #1;
    bus_auto = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_ready = 1'b0; rsp_valid = 1'b0;
    in_valid = 1'b1; rd_wr_en = 1'b1; rd_idx = 5'd3; alu_res = BASE + 64'd8;
    mem_rd = 1'b1; mem_wr = 1'b0; mem_size = 2'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    chk("rtest_req_valid", 64'(req_valid), 64'd1);
    @(posedge clk); #1;
    req_ready = 1'b0;
    @(negedge clk);
    chk("rtest_in_resp_req", 64'(req_valid), 64'd0);
    chk("rtest_in_resp_out", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    rsp_valid = 1'b1; rsp_rdata = {$urandom, $urandom};
    @(negedge clk);
    chk("rtest_idle_ready", 64'(in_ready), 64'd1);
    chk("rtest_idle_req", 64'(req_valid), 64'd0);
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rtest_no_out", 64'(out_valid), 64'd0);
      chk("rtest_ready", 64'(in_ready), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
